// File: rtl/mux_n_to_1_pipe.sv
// -----------------------------------------------------------------------------
// mux_n_to_1_pipe
//
// Registered N-to-1 datapath multiplexer with valid/ready flow control.
// Selects one of N_INPUTS packed WIDTH-bit inputs and registers it for one
// cycle. The output register holds the value while downstream stalls. A
// select value with no matching input yields zero data and raises sel_err
// alongside that beat.
//
// Optional build macro: MUX_PIPE_SKID_BUF_EN
//   Undefined (default): in_ready = !out_valid || out_ready (combinational).
//   Defined            : a one-entry skid buffer is added and in_ready comes
//                        straight from a flop (in_ready = !skid_valid), so
//                        there is no combinational path from out_ready.
//
// Parameters:
//   WIDTH     - width of each input and of the output
//   N_INPUTS  - number of data inputs (2..16)
//   SEL_WIDTH - select width, 2**SEL_WIDTH must be >= N_INPUTS
//
// Ports:
//   clk       in   rising-edge system clock
//   rst_n     in   asynchronous active-low reset
//   in_data   in   packed inputs, input k at [k*WIDTH +: WIDTH]
//   select    in   index of the input to forward
//   in_valid  in   in_data/select valid this cycle
//   in_ready  out  block can accept a beat this cycle
//   out_data  out  registered selected data
//   out_sel   out  select value that produced out_data
//   out_valid out  out_data/out_sel/sel_err valid
//   out_ready in   downstream accepts this cycle
//   sel_err   out  current output came from an out-of-range select
// -----------------------------------------------------------------------------
module mux_n_to_1_pipe #(
    parameter int WIDTH     = 16,
    parameter int N_INPUTS  = 4,
    parameter int SEL_WIDTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_INPUTS*WIDTH-1:0] in_data,
    input  logic [SEL_WIDTH-1:0]      select,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_WIDTH-1:0]      out_sel,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      sel_err
);

    // Combinational pick of the addressed input.
    logic [WIDTH-1:0] pick_data;
    logic             pick_err;

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; without
        // them an unmatched select would infer a latch.
        pick_data = '0;
        pick_err  = 1'b1;
        for (int k = 0; k < N_INPUTS; k++) begin
            if (int'(select) == k) begin
                pick_data = in_data[k*WIDTH +: WIDTH];
                pick_err  = 1'b0;
            end
        end
    end

    // Output register.
    logic [WIDTH-1:0]     data_q;
    logic [SEL_WIDTH-1:0] sel_q;
    logic                 err_q;
    logic                 valid_q;

    logic in_fire;
    logic out_free;   // output register can take a new beat at this edge

    assign out_free = !valid_q || out_ready;
    assign in_fire  = in_valid && in_ready;

`ifdef MUX_PIPE_SKID_BUF_EN

    // Skid entry: holds the one beat accepted while the output was stalled.
    logic [WIDTH-1:0]     skid_data;
    logic [SEL_WIDTH-1:0] skid_sel;
    logic                 skid_err;
    logic                 skid_valid;

    // Flop-driven ready: the skid entry absorbs the beat that arrives in the
    // cycle the output stalls, so ready never has to look at out_ready.
    assign in_ready = !skid_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data/select/error holding registers are reset too,
            // since the outputs must read zero immediately on reset.
            data_q     <= '0;
            sel_q      <= '0;
            err_q      <= 1'b0;
            valid_q    <= 1'b0;
            skid_data  <= '0;
            skid_sel   <= '0;
            skid_err   <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            if (skid_valid) begin
                // Older beat waiting: it must reach the output before any
                // new beat is accepted (in_ready is low here).
                if (out_free) begin
                    data_q     <= skid_data;
                    sel_q      <= skid_sel;
                    err_q      <= skid_err;
                    valid_q    <= 1'b1;
                    skid_valid <= 1'b0;
                end
            end else if (in_fire) begin
                if (out_free) begin
                    data_q  <= pick_data;
                    sel_q   <= select;
                    err_q   <= pick_err;
                    valid_q <= 1'b1;
                end else begin
                    skid_data  <= pick_data;
                    skid_sel   <= select;
                    skid_err   <= pick_err;
                    skid_valid <= 1'b1;
                end
            end else if (out_ready) begin
                // Drained with nothing behind it; data_q keeps its value.
                valid_q <= 1'b0;
            end
        end
    end

`else

    assign in_ready = out_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            sel_q   <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else if (in_fire) begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, whatever order the statements appear in.
            data_q  <= pick_data;
            sel_q   <= select;
            err_q   <= pick_err;
            valid_q <= 1'b1;
        end else if (out_ready) begin
            // Drained with nothing behind it; data_q keeps its value.
            valid_q <= 1'b0;
        end
    end

`endif

    assign out_data  = data_q;
    assign out_sel   = sel_q;
    assign sel_err   = err_q;
    assign out_valid = valid_q;

endmodule

// File: doc/mux_n_to_1_pipe.md
Name: mux_n_to_1_pipe

Overview:
Parametrised, registered N-to-1 datapath multiplexer with valid/ready flow control. It is the successor to the fixed 16-bit 2-to-1 combinational select used in the RISC datapath, for write-back and operand-source selection where the selected value must be pipelined and able to stall. It adds a configurable input count and width, one cycle of registration, backpressure handling and out-of-range select detection.

Parameters:
WIDTH, 16, data width of each input and of the output
N_INPUTS, 4, number of data inputs (2..16)
SEL_WIDTH, 2, select width; 2**SEL_WIDTH >= N_INPUTS is required

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_data  input  N_INPUTS*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH]
select  input  SEL_WIDTH  index of input to forward
in_valid  input  1  in_data/select valid this cycle
in_ready  output  1  block can accept this cycle
out_data  output  WIDTH  registered selected data
out_sel  output  SEL_WIDTH  select value that produced out_data
out_valid  output  1  out_data/out_sel/sel_err valid
out_ready  input  1  downstream accepts this cycle
sel_err  output  1  current output came from an out-of-range select

Behaviour:
- Single clock domain. rst_n is asynchronous and active-low: assertion clears state immediately, independent of clk. Deassertion is synchronous to clk, handled by the system reset logic.
- Reset values: out_valid=0, out_data=0, out_sel=0, sel_err=0, all internal buffers empty.
- Input transfer: in_valid && in_ready at a rising edge. Output transfer: out_valid && out_ready at a rising edge.
- Latency: exactly 1 cycle from input transfer to out_valid=1 when the output stage is empty or draining.
- Selection: out_data <= in_data[select*WIDTH +: WIDTH] when select < N_INPUTS. Otherwise out_data <= 0 and sel_err <= 1.
- sel_err is registered with the data and is valid only while out_valid=1.
- out_sel <= select is captured on every input transfer.
- Stall: while out_valid && !out_ready, out_data, out_sel and sel_err hold stable. No data is dropped or duplicated.
- Without the optional feature, in_ready = !out_valid || out_ready (combinational). Simultaneous output drain and input accept in the same cycle loads the new value, so out_valid stays 1.
- Output drains with no new input: out_valid <= 0 next cycle, and out_data holds its last value.
- in_valid=0: the input stage ignores in_data and select completely.
- in_data and select are sampled only on a transfer cycle.
- Reset mid-stall: all data is discarded and outputs return to reset values immediately.
- Ordering is strictly FIFO, at most one beat per cycle in each direction.

Optional Feature:
Macro MUX_PIPE_SKID_BUF_EN.
- Defined: adds a one-entry skid buffer so that in_ready is driven directly from a flop (in_ready = !skid_valid) with no combinational path from out_ready.
  - On an input transfer while the output is stalled, the beat is captured in the skid buffer (data, select, error).
  - When the output drains, the skid entry moves to the output register on the next edge, and in_ready returns to 1 one cycle after that.
  - Throughput stays 1 beat/cycle and latency stays 1 cycle when not stalled. Up to 2 beats can be held.
  - Reset clears skid_valid.
- Undefined: no skid buffer exists, and in_ready is the combinational expression given above.

Test Plan:
- Reset: rst_n=0 mid-cycle with out_valid=1 -> out_valid, out_data, sel_err all 0 before the next clk edge; in_ready=1 after release.
- Basic select: WIDTH=16, N_INPUTS=4, in_data={16'd1000,16'd456,16'd123,16'd7}, select=2, out_ready=1 -> one cycle later out_data=456, out_sel=2, out_valid=1, sel_err=0.
- Streaming: select sequence 0,1,2,3 on consecutive cycles with out_ready=1 -> out_data 7,123,456,1000 on consecutive cycles, no bubbles.
- Out of range: N_INPUTS=3, select=3, in_valid=1 -> out_data=0, sel_err=1; next beat with select=1 -> sel_err=0, out_data equals input 1.
- Backpressure: out_ready=0 for 5 cycles while holding out_data=123 -> output stable, in_ready=0 (no macro) or in_ready=1 for exactly one extra beat then 0 (with macro); release out_ready -> all beats emerge in order, none lost.
- Simultaneous drain and accept: out_valid=1, out_ready=1, in_valid=1 with select=0 -> out_valid stays 1 and out_data=7 next cycle.
